// File: rtl/pcler8_down_timer.sv
// pcler8_down_timer: registered 8-bit loadable down-counter for the pcler8
// family. A load starts a countdown from load_val towards zero. Reaching zero
// raises a terminal-count flag that stays high until it is acknowledged.
// Control priority on each edge: rst_n > clr > load > tc_ack > en.
//
// Optional feature macro: PCLER8_AUTO_RELOAD_EN
//   When defined, a reload register captures load_val on every load. Each
//   time the count reaches terminal in RUN, the count reloads from that
//   register, the counter stays in RUN and tc pulses for one cycle. A reload
//   value of zero falls back to the plain DONE/ack behaviour.
//   When undefined, there is no reload register.
module pcler8_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             tc_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_busy;
  logic             r_tc;

  // A count of 1 (or a stray 0) in RUN means the next enabled edge is terminal,
  // so the count can never be decremented below zero.
  logic             w_terminal;
  logic             w_load_nonzero;

  assign w_terminal     = (r_count <= WIDTH'(1));
  assign w_load_nonzero = (load_val != {WIDTH{1'b0}});

`ifdef PCLER8_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
  logic             w_reload_nonzero;

  assign w_reload_nonzero = (r_reload != {WIDTH{1'b0}});

  // Reload register: follows every load and survives clr (only reset clears it).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reload <= {WIDTH{1'b0}};
    end else if (!clr && load) begin
      r_reload <= load_val;
    end else begin
      r_reload <= r_reload;
    end
  end
`endif

  // Control FSM with registered count, busy and tc outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_count <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      if (w_load_nonzero) begin
        r_state <= ST_RUN;
        r_busy  <= 1'b1;
        r_tc    <= 1'b0;
      end else begin
        r_state <= ST_DONE;
        r_busy  <= 1'b0;
        r_tc    <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
          r_count <= r_count;
          r_busy  <= 1'b0;
          r_tc    <= 1'b0;
        end
        ST_RUN: begin
          if (en && w_terminal) begin
`ifdef PCLER8_AUTO_RELOAD_EN
            if (w_reload_nonzero) begin
              r_state <= ST_RUN;
              r_count <= r_reload;
              r_busy  <= 1'b1;
              r_tc    <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_count <= {WIDTH{1'b0}};
              r_busy  <= 1'b0;
              r_tc    <= 1'b1;
            end
`else
            r_state <= ST_DONE;
            r_count <= {WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_tc    <= 1'b1;
`endif
          end else if (en) begin
            r_state <= ST_RUN;
            r_count <= r_count - WIDTH'(1);
            r_busy  <= 1'b1;
            r_tc    <= 1'b0;
          end else begin
            r_state <= ST_RUN;
            r_count <= r_count;
            r_busy  <= 1'b1;
            r_tc    <= 1'b0;
          end
        end
        ST_DONE: begin
          r_count <= {WIDTH{1'b0}};
          r_busy  <= 1'b0;
          if (tc_ack) begin
            r_state <= ST_IDLE;
            r_tc    <= 1'b0;
          end else begin
            r_state <= ST_DONE;
            r_tc    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= {WIDTH{1'b0}};
          r_busy  <= 1'b0;
          r_tc    <= 1'b0;
        end
      endcase
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign tc    = r_tc;

endmodule

// File: tb/tb_pcler8_down_timer.sv
// Self-checking bench for pcler8_down_timer. A reference model predicts
// {count, busy, tc} for each driven cycle; predictions are queued when the
// stimulus is applied and compared after the DUT clock edge.
module tb_pcler8_down_timer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       tc_ack;
  logic [7:0] count;
  logic       busy;
  logic       tc;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [7:0] m_count;
  int         m_state;   // 0 idle, 1 run, 2 done
  logic       m_pulse;
  logic [7:0] m_reload;

  logic [9:0] exp_q[$];

  pcler8_down_timer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .tc_ack(tc_ack), .count(count), .busy(busy), .tc(tc)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance the reference model by one clock edge.
  task automatic model_edge(input logic r, input logic c, input logic ld,
                            input logic [7:0] lv, input logic e, input logic a);
    m_pulse = 1'b0;
    if (!r) begin
      m_count = 8'd0; m_state = 0; m_reload = 8'd0;
    end else if (c) begin
      m_count = 8'd0; m_state = 0;
    end else if (ld) begin
      m_count  = lv;
      m_reload = lv;
      m_state  = (lv == 8'd0) ? 2 : 1;
    end else if (m_state == 2) begin
      if (a) m_state = 0;
      m_count = 8'd0;
    end else if (m_state == 1 && e) begin
      if (m_count == 8'd1) begin
`ifdef PCLER8_AUTO_RELOAD_EN
        if (m_reload != 8'd0) begin
          m_count = m_reload;
          m_pulse = 1'b1;
        end else begin
          m_count = 8'd0;
          m_state = 2;
        end
`else
        m_count = 8'd0;
        m_state = 2;
`endif
      end else begin
        m_count = m_count - 8'd1;
      end
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic c, input logic ld,
                      input logic [7:0] lv, input logic e, input logic a);
    logic [9:0] exp_v;
    @(negedge clk);
    rst_n = r; clr = c; load = ld; load_val = lv; en = e; tc_ack = a;
    model_edge(r, c, ld, lv, e, a);
    exp_q.push_back({m_count, (m_state == 1), ((m_state == 2) || m_pulse)});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    chk({tag, ".count"}, int'(count), int'(exp_v[9:2]));
    chk({tag, ".busy"},  int'(busy),  int'(exp_v[1]));
    chk({tag, ".tc"},    int'(tc),    int'(exp_v[0]));
  endtask

  initial begin
    int n;
    n_cmp = 0; n_bad = 0;
    m_count = 8'd0; m_state = 0; m_pulse = 1'b0; m_reload = 8'd0;
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0; en = 1'b0; tc_ack = 1'b0;

    // Reset held two cycles with a load pending
    step("rst0", 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step("rel",  1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("reset_count_const", int'(count), 0);

    // Basic countdown from 5
    step("ld5", 1'b1, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0);
    chk("busy_after_load", int'(busy), 1);
    for (int i = 0; i < 5; i++) step("cnt5", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    chk("tc_at_5", int'(tc), 1);
    step("hold_tc", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("ack5",    1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    chk("tc_after_ack", int'(tc), 0);
    step("idle_en",  1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("idle_ack", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // Enable gating from 3
    step("ld3", 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
    step("g1", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("g0", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    step("g1", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("g0", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("gate_no_tc_yet", int'(tc), 0);
    step("g1", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    chk("gate_tc", int'(tc), 1);
    step("gack", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // load_val = 0: immediate DONE, busy never asserts
    step("ld0", 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    chk("ld0_busy", int'(busy), 0);
    step("ld0_hold", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("ld0_ack",  1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // load_val = 0xFF counts 255 enabled cycles (bounded wait)
    step("ldff", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    n = 0;
    while (tc !== 1'b1 && n < 300) begin
      step("ff", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      n++;
    end
    chk("ff_cycles", n, 255);

    // Load and ack together while DONE: load wins
    step("ld_ack", 1'b1, 1'b0, 1'b1, 8'd7, 1'b1, 1'b1);
    chk("ld_ack_tc", int'(tc), 0);

    // Clear mid-count with coincident load
    step("ld10", 1'b1, 1'b0, 1'b1, 8'd10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("c10", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("clr_ld", 1'b1, 1'b1, 1'b1, 8'd9, 1'b1, 1'b0);
    chk("clr_count", int'(count), 0);
    step("after_clr", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    // Load 2, en for 7 cycles (reload or single held tc depending on build)
    step("ld2", 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step("ar", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("ar_ack", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

    // Reset mid-count
    step("ld9", 1'b1, 1'b0, 1'b1, 8'd9, 1'b1, 1'b0);
    step("c9",  1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("rst_mid", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    step("rst_rel", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
